// File: rtl/multicycle_ctrl_if.sv
// Handshake and control bundle between the multi-cycle sequencer and the datapath/memory.
// master = the sequencer, slave = the datapath and memory side.
interface multicycle_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic [5:0]       opcode;
   logic             mem_ready;
   logic [2:0]       state;
   logic             mem_req;
   logic             mem_we;
   logic             ir_we;
   logic             pc_we;
   logic [1:0]       pc_src;
   logic [1:0]       alu_op;
   logic             reg_we;
   logic             busy;
   logic             halted;
   logic             illegal;
   logic [CNT_W-1:0] retired;
   logic [CNT_W-1:0] stalls;

   modport master (
      input  start, opcode, mem_ready,
      output state, mem_req, mem_we, ir_we, pc_we, pc_src, alu_op, reg_we,
             busy, halted, illegal, retired, stalls
   );

   modport slave (
      output start, opcode, mem_ready,
      input  state, mem_req, mem_we, ir_we, pc_we, pc_src, alu_op, reg_we,
             busy, halted, illegal, retired, stalls
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the multi-cycle core: FETCH/DECODE/EXEC/MEM/WB plus IDLE and HALT.
// Define MULTICYCLE_CTRL_PERF_EN to build the retired/stall performance counters.
module multicycle_ctrl #(
   parameter logic [5:0] HALT_OPCODE = 6'h3F,
   parameter int         CNT_W       = 16
) (
   input logic               clk,
   input logic               rst_n,
   multicycle_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_IDLE   = 3'd5,
      ST_HALT   = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      CL_RTYPE   = 3'd0,
      CL_ADDI    = 3'd1,
      CL_LOAD    = 3'd2,
      CL_STORE   = 3'd3,
      CL_BRANCH  = 3'd4,
      CL_JUMP    = 3'd5,
      CL_HALT    = 3'd6,
      CL_ILLEGAL = 3'd7
   } op_class_t;

   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2B;
   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] OPC_BNE   = 6'h05;
   localparam logic [5:0] OPC_J     = 6'h02;

   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNC  = 2'b10;

   state_t    state_r;
   state_t    state_next_s;
   op_class_t op_class_s;
   logic      mem_req_s;
   logic      mem_we_s;
   logic      ir_we_s;
   logic      pc_we_s;
   logic [1:0] pc_src_s;
   logic [1:0] alu_op_s;
   logic      reg_we_s;
   logic      illegal_set_s;
   logic      illegal_r;

   // Opcode classification; the halt opcode is a parameter so it takes priority over the table.
   always_comb begin
      op_class_s = CL_ILLEGAL;
      if (bus.opcode == HALT_OPCODE) begin
         op_class_s = CL_HALT;
      end else begin
         case (bus.opcode)
            OPC_RTYPE: op_class_s = CL_RTYPE;
            OPC_ADDI:  op_class_s = CL_ADDI;
            OPC_LW:    op_class_s = CL_LOAD;
            OPC_SW:    op_class_s = CL_STORE;
            OPC_BEQ,
            OPC_BNE:   op_class_s = CL_BRANCH;
            OPC_J:     op_class_s = CL_JUMP;
            default:   op_class_s = CL_ILLEGAL;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state and control outputs.
   always_comb begin
      state_next_s  = state_r;
      mem_req_s     = 1'b0;
      mem_we_s      = 1'b0;
      ir_we_s       = 1'b0;
      pc_we_s       = 1'b0;
      pc_src_s      = PC_SEQ;
      alu_op_s      = ALU_ADD;
      reg_we_s      = 1'b0;
      illegal_set_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_next_s = ST_FETCH;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            mem_req_s = 1'b1;
            if (bus.mem_ready) begin
               ir_we_s      = 1'b1;
               pc_we_s      = 1'b1;
               pc_src_s     = PC_SEQ;
               state_next_s = ST_DECODE;
            end else begin
               state_next_s = ST_FETCH;
            end
         end
         ST_DECODE: begin
            state_next_s = ST_EXEC;
         end
         ST_EXEC: begin
            case (op_class_s)
               CL_RTYPE: begin
                  alu_op_s     = ALU_FUNC;
                  state_next_s = ST_WB;
               end
               CL_ADDI: begin
                  alu_op_s     = ALU_ADD;
                  state_next_s = ST_WB;
               end
               CL_LOAD,
               CL_STORE: begin
                  alu_op_s     = ALU_ADD;
                  state_next_s = ST_MEM;
               end
               CL_BRANCH: begin
                  alu_op_s     = ALU_SUB;
                  pc_we_s      = 1'b1;
                  pc_src_s     = PC_BRANCH;
                  state_next_s = ST_FETCH;
               end
               CL_JUMP: begin
                  pc_we_s      = 1'b1;
                  pc_src_s     = PC_JUMP;
                  state_next_s = ST_FETCH;
               end
               CL_HALT: begin
                  state_next_s = ST_HALT;
               end
               default: begin
                  illegal_set_s = 1'b1;
                  state_next_s  = ST_FETCH;
               end
            endcase
         end
         ST_MEM: begin
            // Opcode is held by the datapath through MEM, so it still selects load vs store here.
            mem_req_s = 1'b1;
            mem_we_s  = (op_class_s == CL_STORE);
            if (bus.mem_ready) begin
               if (op_class_s == CL_STORE) begin
                  state_next_s = ST_FETCH;
               end else begin
                  state_next_s = ST_WB;
               end
            end else begin
               state_next_s = ST_MEM;
            end
         end
         ST_WB: begin
            reg_we_s     = 1'b1;
            state_next_s = ST_FETCH;
         end
         ST_HALT: begin
            state_next_s = ST_HALT;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Sticky illegal-opcode flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_r <= 1'b0;
      end else if (illegal_set_s) begin
         illegal_r <= 1'b1;
      end else begin
         illegal_r <= illegal_r;
      end
   end

`ifdef MULTICYCLE_CTRL_PERF_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             retire_s;
   logic             stall_s;
   logic [CNT_W-1:0] retired_r;
   logic [CNT_W-1:0] stalls_r;

   // An instruction retires when control leaves EXEC/MEM/WB for FETCH, or enters HALT.
   always_comb begin
      retire_s = 1'b0;
      if ((state_next_s == ST_FETCH) &&
          ((state_r == ST_EXEC) || (state_r == ST_MEM) || (state_r == ST_WB))) begin
         retire_s = 1'b1;
      end else if ((state_next_s == ST_HALT) && (state_r == ST_EXEC)) begin
         retire_s = 1'b1;
      end else begin
         retire_s = 1'b0;
      end
   end

   assign stall_s = mem_req_s & ~bus.mem_ready;

   // Wrapping performance counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_r <= {CNT_W{1'b0}};
         stalls_r  <= {CNT_W{1'b0}};
      end else begin
         if (retire_s) begin
            retired_r <= retired_r + CNT_ONE;
         end
         if (stall_s) begin
            stalls_r <= stalls_r + CNT_ONE;
         end
      end
   end

   assign bus.retired = retired_r;
   assign bus.stalls  = stalls_r;
`else
   assign bus.retired = {CNT_W{1'b0}};
   assign bus.stalls  = {CNT_W{1'b0}};
`endif

   assign bus.state   = state_r;
   assign bus.mem_req = mem_req_s;
   assign bus.mem_we  = mem_we_s;
   assign bus.ir_we   = ir_we_s;
   assign bus.pc_we   = pc_we_s;
   assign bus.pc_src  = pc_src_s;
   assign bus.alu_op  = alu_op_s;
   assign bus.reg_we  = reg_we_s;
   assign bus.busy    = (state_r != ST_IDLE) && (state_r != ST_HALT);
   assign bus.halted  = (state_r == ST_HALT);
   assign bus.illegal = illegal_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instructions plus a random instruction
// stream, checked cycle by cycle against an instruction-level model of the sequencer.
module tb_multicycle_ctrl;
   localparam int CNT_W = 16;

   // {mem_req, mem_we, ir_we, pc_we, pc_src[1:0], alu_op[1:0], reg_we}
   localparam logic [8:0] CTL_NONE   = 9'b0_0_0_0_00_00_0;
   localparam logic [8:0] CTL_FWAIT  = 9'b1_0_0_0_00_00_0;
   localparam logic [8:0] CTL_FDONE  = 9'b1_0_1_1_00_00_0;
   localparam logic [8:0] CTL_MEM_LD = 9'b1_0_0_0_00_00_0;
   localparam logic [8:0] CTL_MEM_ST = 9'b1_1_0_0_00_00_0;
   localparam logic [8:0] CTL_WB     = 9'b0_0_0_0_00_00_1;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail = 0;
   logic ill_m;
   logic [CNT_W-1:0] ret_m;
   logic [CNT_W-1:0] stl_m;

   always #5 clk = ~clk;

   multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

   multicycle_ctrl #(.HALT_OPCODE(6'h3F), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic r1();
      return 1'($urandom);
   endfunction

   function automatic logic [5:0] r6();
      return 6'($urandom);
   endfunction

   function automatic logic is_known(input logic [5:0] op);
      return (op == 6'h00) || (op == 6'h08) || (op == 6'h23) || (op == 6'h2B) ||
             (op == 6'h04) || (op == 6'h05) || (op == 6'h02) || (op == 6'h3F);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag);
`ifdef MULTICYCLE_CTRL_PERF_EN
      chk({tag, "_retired"}, 32'(bus.retired), 32'(ret_m));
      chk({tag, "_stalls"}, 32'(bus.stalls), 32'(stl_m));
`else
      chk({tag, "_retired"}, 32'(bus.retired), 32'd0);
      chk({tag, "_stalls"}, 32'(bus.stalls), 32'd0);
`endif
   endtask

   // One clock cycle: drive inputs, check state and all outputs, advance to the next edge + 1.
   task automatic step(input logic [2:0] es, input logic [8:0] ectl, input logic rdy,
                       input logic [5:0] op, input logic st);
      logic [11:0] exp_v;
      logic [11:0] obs_v;
      bus.mem_ready = rdy;
      bus.opcode    = op;
      bus.start     = st;
      #1;
      exp_v = {ectl, (es != 3'd5) && (es != 3'd7), (es == 3'd7), ill_m};
      obs_v = {bus.mem_req, bus.mem_we, bus.ir_we, bus.pc_we, bus.pc_src, bus.alu_op,
               bus.reg_we, bus.busy, bus.halted, bus.illegal};
      chk("state", 32'(bus.state), 32'(es));
      chk("ctl", 32'(obs_v), 32'(exp_v));
      @(posedge clk);
      #1;
   endtask

   // Full instruction from the FETCH cycle onward, with fw fetch and mw memory wait cycles.
   task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
      logic [8:0] ectl;
      int         kind; // 0 to WB, 1 to MEM, 2 to FETCH, 3 to HALT
      logic       bad;
      bad = 1'b0;
      for (int i = 0; i < fw; i++) begin
         step(3'd0, CTL_FWAIT, 1'b0, r6(), r1());
         stl_m++;
      end
      step(3'd0, CTL_FDONE, 1'b1, r6(), r1());
      step(3'd1, CTL_NONE, r1(), r6(), r1());
      case (op)
         6'h00:        begin ectl = 9'b0_0_0_0_00_10_0; kind = 0; end
         6'h08:        begin ectl = 9'b0_0_0_0_00_00_0; kind = 0; end
         6'h23, 6'h2B: begin ectl = 9'b0_0_0_0_00_00_0; kind = 1; end
         6'h04, 6'h05: begin ectl = 9'b0_0_0_1_01_01_0; kind = 2; end
         6'h02:        begin ectl = 9'b0_0_0_1_10_00_0; kind = 2; end
         6'h3F:        begin ectl = CTL_NONE; kind = 3; end
         default:      begin ectl = CTL_NONE; kind = 2; bad = 1'b1; end
      endcase
      step(3'd2, ectl, r1(), op, r1());
      if (bad) ill_m = 1'b1;
      if (kind == 1) begin
         for (int i = 0; i < mw; i++) begin
            step(3'd3, (op == 6'h2B) ? CTL_MEM_ST : CTL_MEM_LD, 1'b0, op, r1());
            stl_m++;
         end
         step(3'd3, (op == 6'h2B) ? CTL_MEM_ST : CTL_MEM_LD, 1'b1, op, r1());
         if (op == 6'h23) kind = 0;
      end
      if (kind == 0) step(3'd4, CTL_WB, r1(), op, r1());
      ret_m++;
      if (kind == 3) begin
         for (int i = 0; i < 4; i++) step(3'd7, CTL_NONE, r1(), r6(), 1'b1);
      end
      chk_cnt("instr");
   endtask

   initial begin
      logic [5:0] op;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.opcode = 6'h00;
      bus.mem_ready = 1'b0;
      ill_m = 1'b0;
      ret_m = '0;
      stl_m = '0;
      repeat (2) @(posedge clk);
      #1;
      step(3'd5, CTL_NONE, 1'b1, 6'h00, 1'b1);
      chk_cnt("reset");
      bus.start = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      step(3'd5, CTL_NONE, r1(), r6(), 1'b0);
      step(3'd5, CTL_NONE, 1'b1, 6'h00, 1'b1);
      run_instr(6'h00, 0, 0);
      run_instr(6'h23, 2, 1);
      run_instr(6'h2B, 0, 0);
      run_instr(6'h04, 0, 0);
      run_instr(6'h11, 1, 0);
      run_instr(6'h08, 0, 2);

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 7))
            0: op = 6'h00;
            1: op = 6'h08;
            2: op = 6'h23;
            3: op = 6'h2B;
            4: op = 6'h04;
            5: op = 6'h05;
            6: op = 6'h02;
            default: begin
               op = r6();
               while (is_known(op)) op = r6();
            end
         endcase
         run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      run_instr(6'h3F, $urandom_range(0, 2), 0);

      // Reset out of HALT clears the sticky flag and the counters.
      rst_n = 1'b0;
      ill_m = 1'b0;
      ret_m = '0;
      stl_m = '0;
      step(3'd5, CTL_NONE, r1(), r6(), 1'b1);
      chk_cnt("halt_reset");
      bus.start = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Load stalled in MEM, then reset asserted asynchronously mid-cycle.
      step(3'd5, CTL_NONE, 1'b1, 6'h00, 1'b1);
      step(3'd0, CTL_FDONE, 1'b1, r6(), 1'b0);
      step(3'd1, CTL_NONE, r1(), r6(), 1'b0);
      step(3'd2, 9'b0_0_0_0_00_00_0, r1(), 6'h23, 1'b0);
      step(3'd3, CTL_MEM_LD, 1'b0, 6'h23, 1'b0);
      stl_m++;
      bus.mem_ready = 1'b0;
      bus.opcode = 6'h23;
      #1;
      chk("pre_rst_state", 32'(bus.state), 32'd3);
      chk_cnt("pre_rst");
      #2;
      rst_n = 1'b0;
      stl_m = '0;
      #1;
      chk("async_rst_state", 32'(bus.state), 32'd5);
      chk("async_rst_ctl", 32'({bus.mem_req, bus.mem_we, bus.ir_we, bus.pc_we, bus.pc_src,
                               bus.alu_op, bus.reg_we, bus.busy, bus.halted, bus.illegal}),
          32'd0);
      chk_cnt("async_rst");
      @(posedge clk);
      #1;
      step(3'd5, CTL_NONE, 1'b1, r6(), 1'b1);
      bus.start = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(3'd5, CTL_NONE, 1'b1, r6(), 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main sequencing FSM for the multi-cycle core. Drives the 3-bit `state` bus that the fetch, decode, execute, memory and writeback datapath stages qualify on, so the decode stage latches instruction fields only while `state == 1`. Handshakes with instruction/data memory and issues write enables for PC, IR and the register file. Retires one instruction per pass through the FSM.

## Interface
- `HALT_OPCODE`, 6'h3F, opcode that stops the core
- `CNT_W`, 16, width of performance counters
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin execution; sampled only in IDLE
- `opcode`  in  6  decoded opcode; valid from the EXEC cycle onward
- `mem_ready`  in  1  memory completes the current request this cycle
- `state`  out  3  FSM state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, IDLE=5, HALT=7
- `mem_req`  out  1  memory request (FETCH and MEM)
- `mem_we`  out  1  data write (MEM state, store only)
- `ir_we`  out  1  load IR from memory data
- `pc_we`  out  1  PC update
- `pc_src`  out  2  00 PC+4, 01 branch target, 10 jump target
- `alu_op`  out  2  00 add, 01 sub, 10 use func field
- `reg_we`  out  1  register file write
- `busy`  out  1  high in any state except IDLE/HALT
- `halted`  out  1  high in HALT
- `illegal`  out  1  sticky: unknown opcode executed
- `retired`  out  CNT_W  instructions retired
- `stalls`  out  CNT_W  cycles with mem_req high and mem_ready low

## Operation
- All control outputs are Moore/Mealy combinational from the registered state and inputs; `state`, `illegal`, and the counters are registered.
- IDLE: `start`=1 → FETCH.
- FETCH: `mem_req`=1. Stays in FETCH until `mem_ready`=1. On that cycle `ir_we`=1, `pc_we`=1, `pc_src`=00, and the next state is DECODE.
- DECODE: single cycle, no enables → EXEC.
- EXEC, by opcode:
  - 000000 (R-type): `alu_op`=10 → WB.
  - 001000 (addi): `alu_op`=00 → WB.
  - 100011 (lw) / 101011 (sw): `alu_op`=00 → MEM.
  - 000100 (beq) / 000101 (bne): `alu_op`=01, `pc_we`=1, `pc_src`=01 → FETCH. The datapath gates the PC write with the zero flag.
  - 000010 (j): `pc_we`=1, `pc_src`=10 → FETCH.
  - HALT_OPCODE → HALT.
  - Any other opcode sets `illegal` and goes to FETCH as a no-op.
- MEM: `mem_req`=1, and `mem_we`=1 for sw. Waits for `mem_ready`. On ready, lw → WB and sw → FETCH.
- WB: `reg_we`=1 → FETCH.
- HALT: terminal. Only `rst_n` exits it; `start` is ignored.
- `retired` increments on every transition into FETCH from EXEC, MEM or WB, and on entry to HALT. It wraps at 2^CNT_W.
- `stalls` increments every cycle with `mem_req`=1 and `mem_ready`=0. It wraps.
- `mem_ready` is ignored when `mem_req`=0.
- In any non-EXEC state, `alu_op`=00 and `pc_src`=00.

## Timing
- Reset (async assert, sync release): `state`=IDLE(5). Every other output is 0 and the counters clear.
- Reset asserted mid-instruction aborts immediately. No enable pulses are issued after assertion.
- Minimum latency with zero-wait memory:
  - R-type/addi/lw-less: 4 cycles (F, D, E, W).
  - lw: 5 cycles.
  - sw: 4 cycles.
  - branch/jump: 3 cycles.
- Each wait cycle adds 1 cycle of latency.
- `ir_we`, `pc_we` and `reg_we` each pulse exactly one cycle per qualifying event.
- `mem_req` stays high continuously, without dropping, until the `mem_ready` cycle.
- `mem_ready` arriving in the same cycle as the request entry (zero wait) completes that cycle.

## Configuration
- `MULTICYCLE_CTRL_PERF_EN`:
  - Defined: `retired` and `stalls` counters are implemented as described.
  - Undefined: both outputs are tied to 0, no counter flops exist, and all other behaviour is identical.

## Test plan
- Reset, then `start`=1 with R-type opcode 6'h00 and mem_ready tied 1 → states 5,0,1,2,4,0. `reg_we` pulses in the WB cycle. `retired`=1.
- lw (6'h23) with mem_ready low for 2 cycles in FETCH and 1 in MEM → states 0,0,0,1,2,3,3,4. `stalls`=3. `mem_we` stays 0.
- sw (6'h2B), zero wait → MEM cycle shows `mem_req`=1, `mem_we`=1. Next state is FETCH and `reg_we` never asserts.
- beq (6'h04) → EXEC shows `pc_we`=1, `pc_src`=01, `alu_op`=01. Then opcode 6'h3F → HALT, with `halted`=1, `busy`=0, and `start` ignored.
- Opcode 6'h11 → `illegal` rises after EXEC and stays high through later instructions until `rst_n`.
- `rst_n` driven low mid-MEM → `state`=5 asynchronously, all enables 0, counters 0. Without the macro, `retired`/`stalls` read 0 throughout.
